// File: rtl/mcu_cmd_decoder.sv
// mcu_cmd_decoder: byte-level command decoder in the clk_dot4x domain.
// Parses write/read frames from the MCU byte stream, updates a bank of
// 8-bit configuration registers and queues one response byte per frame
// into a pulse/gap transmitter with a one-entry pending slot.
// Optional feature macro: CMD_CHECKSUM_EN adds a fourth XOR checksum byte
// to every frame.
module mcu_cmd_decoder #(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] ID_BYTE  = 8'h56,
  parameter int         TIMEOUT  = 65536,
  parameter int         TX_PULSE = 4,
  parameter int         TX_GAP   = 4096
) (
  input  logic                  clk_dot4x_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_4x_i,
  input  logic                  rx_new_data_4x_i,
  output logic [7:0]            tx_data_4x_o,
  output logic                  tx_new_data_4x_o,
  output logic [8*NUM_REGS-1:0] cfg_regs_o,
  output logic                  cfg_wr_o,
  output logic [7:0]            cfg_addr_o,
  output logic                  resp_ovf_o
);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RESP_OK   = 8'hA5;
  localparam logic [7:0] RESP_ERR  = 8'hEE;
  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMW  = $clog2(TIMEOUT + 1);
  localparam int TXW  = $clog2(TX_PULSE + TX_GAP + 1);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [2:0] {P_IDLE, P_GOT_CMD, P_GOT_ADDR, P_GOT_DATA, P_EXEC} parseState_t;
`else
  typedef enum logic [1:0] {P_IDLE, P_GOT_CMD, P_GOT_ADDR, P_EXEC} parseState_t;
`endif

  typedef enum logic [1:0] {TXS_IDLE, TXS_PULSE, TXS_GAP} txState_t;

  parseState_t parseState_q, parseState_d;
  logic [TMW-1:0] timer_q, timer_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  logic [7:0] regs_q [NUM_REGS];
  logic cfgWr_q;
  logic [7:0] cfgAddr_q;

  txState_t txState_q, txState_d;
  logic [TXW-1:0] txCnt_q, txCnt_d;
  logic [7:0] txData_q, txData_d;
  logic slotFull_q, slotFull_d;
  logic [7:0] slotData_q, slotData_d;
  logic respOvf_q, respOvf_d;

  logic timeoutFire;
  logic chkOk;
  logic addrInRange;
  logic [IDXW-1:0] addrIdx;
  logic [7:0] readValue;
  logic execValid;
  logic execWrite;
  logic [7:0] execResp;

  // A partial frame is abandoned once the inter-byte counter hits its limit
  assign timeoutFire = (parseState_q != P_IDLE) && (parseState_q != P_EXEC) &&
                       (timer_q == TMW'(TIMEOUT));

`ifdef CMD_CHECKSUM_EN
  assign chkOk = ((cmd_q ^ addr_q ^ data_q) == chk_q);
`else
  assign chkOk = 1'b1;
`endif

  assign addrInRange = ({1'b0, addr_q} < 9'(NUM_REGS));
  assign addrIdx     = addr_q[IDXW-1:0];
  assign readValue   = regs_q[addrIdx];

  // Decode the captured frame during EXEC into a side effect and a response byte
  always_comb begin
    execValid = 1'b0;
    execWrite = 1'b0;
    execResp  = RESP_ERR;
    if (parseState_q == P_EXEC) begin
      execValid = 1'b1;
      if (chkOk) begin
        if (cmd_q == CMD_WRITE && addrInRange && addr_q != 8'd0) begin
          execWrite = 1'b1;
          execResp  = RESP_OK;
        end else if (cmd_q == CMD_READ && addrInRange) begin
          execResp = readValue;
        end
      end
    end
  end

  // Parser next state: one byte strobe per step, timeout drops back to idle
  always_comb begin
    parseState_d = parseState_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    data_d       = data_q;
`ifdef CMD_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    if (timeoutFire) begin
      if (rx_new_data_4x_i) begin
        parseState_d = P_GOT_CMD;
        cmd_d        = rx_data_4x_i;
      end else begin
        parseState_d = P_IDLE;
      end
    end else begin
      case (parseState_q)
        P_IDLE: begin
          if (rx_new_data_4x_i) begin
            parseState_d = P_GOT_CMD;
            cmd_d        = rx_data_4x_i;
          end
        end
        P_GOT_CMD: begin
          if (rx_new_data_4x_i) begin
            parseState_d = P_GOT_ADDR;
            addr_d       = rx_data_4x_i;
          end
        end
        P_GOT_ADDR: begin
          if (rx_new_data_4x_i) begin
            data_d = rx_data_4x_i;
`ifdef CMD_CHECKSUM_EN
            parseState_d = P_GOT_DATA;
`else
            parseState_d = P_EXEC;
`endif
          end
        end
`ifdef CMD_CHECKSUM_EN
        P_GOT_DATA: begin
          if (rx_new_data_4x_i) begin
            parseState_d = P_EXEC;
            chk_d        = rx_data_4x_i;
          end
        end
`endif
        P_EXEC: begin
          if (rx_new_data_4x_i) begin
            parseState_d = P_GOT_CMD;
            cmd_d        = rx_data_4x_i;
          end else begin
            parseState_d = P_IDLE;
          end
        end
        default: parseState_d = P_IDLE;
      endcase
    end
    if (parseState_q == P_IDLE || parseState_q == P_EXEC || rx_new_data_4x_i || timeoutFire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMW'(1);
    end
  end

  // Transmitter: pulse then hold, with a single pending slot and sticky overflow
  always_comb begin
    txState_d  = txState_q;
    txCnt_d    = txCnt_q;
    txData_d   = txData_q;
    slotFull_d = slotFull_q;
    slotData_d = slotData_q;
    respOvf_d  = respOvf_q;
    case (txState_q)
      TXS_IDLE: begin
        if (slotFull_q) begin
          txState_d  = TXS_PULSE;
          txCnt_d    = '0;
          txData_d   = slotData_q;
          slotFull_d = execValid;
          if (execValid) begin
            slotData_d = execResp;
          end
        end else if (execValid) begin
          txState_d = TXS_PULSE;
          txCnt_d   = '0;
          txData_d  = execResp;
        end
      end
      TXS_PULSE: begin
        if (txCnt_q == TXW'(TX_PULSE - 1)) begin
          txCnt_d   = '0;
          txState_d = (TX_GAP == 0) ? TXS_IDLE : TXS_GAP;
        end else begin
          txCnt_d = txCnt_q + TXW'(1);
        end
      end
      TXS_GAP: begin
        if (txCnt_q == TXW'(TX_GAP - 1)) begin
          txCnt_d   = '0;
          txState_d = TXS_IDLE;
        end else begin
          txCnt_d = txCnt_q + TXW'(1);
        end
      end
      default: txState_d = TXS_IDLE;
    endcase
    if (txState_q != TXS_IDLE && execValid) begin
      if (slotFull_q) begin
        respOvf_d = 1'b1;
      end else begin
        slotFull_d = 1'b1;
        slotData_d = execResp;
      end
    end
  end

  // Register bank and write strobe; register 0 holds the ID and is never written
  always_ff @(posedge clk_dot4x_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= (k == 0) ? ID_BYTE : 8'h00;
      end
      cfgWr_q   <= 1'b0;
      cfgAddr_q <= 8'h00;
    end else begin
      cfgWr_q <= execWrite;
      if (execWrite) begin
        regs_q[addrIdx] <= data_q;
        cfgAddr_q       <= addr_q;
      end
    end
  end

  // Parser and transmitter state registers
  always_ff @(posedge clk_dot4x_i) begin
    if (rst_i) begin
      parseState_q <= P_IDLE;
      timer_q      <= '0;
      cmd_q        <= 8'h00;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
`ifdef CMD_CHECKSUM_EN
      chk_q        <= 8'h00;
`endif
      txState_q    <= TXS_IDLE;
      txCnt_q      <= '0;
      txData_q     <= 8'h00;
      slotFull_q   <= 1'b0;
      slotData_q   <= 8'h00;
      respOvf_q    <= 1'b0;
    end else begin
      parseState_q <= parseState_d;
      timer_q      <= timer_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
`ifdef CMD_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
      txState_q    <= txState_d;
      txCnt_q      <= txCnt_d;
      txData_q     <= txData_d;
      slotFull_q   <= slotFull_d;
      slotData_q   <= slotData_d;
      respOvf_q    <= respOvf_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gRegOut
    assign cfg_regs_o[8*g +: 8] = regs_q[g];
  end

  assign tx_data_4x_o     = txData_q;
  assign tx_new_data_4x_o = (txState_q == TXS_PULSE);
  assign cfg_wr_o         = cfgWr_q;
  assign cfg_addr_o       = cfgAddr_q;
  assign resp_ovf_o       = respOvf_q;

endmodule

// File: tb/tb_mcu_cmd_decoder.sv
// Self-checking bench for mcu_cmd_decoder. Expected response bytes are
// queued as frames are driven and popped when the transmitter strobes.
// Define CMD_CHECKSUM_EN to exercise the checksum build.
module tb_mcu_cmd_decoder;

   localparam int NREGS = 16;
   localparam int TOUT  = 100;
   localparam int TXP   = 4;
   localparam int TXG   = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] rxData = 8'h00;
   logic rxNew = 1'b0;
   logic [7:0] txData;
   logic txNew;
   logic [8*NREGS-1:0] cfgRegs;
   logic cfgWr;
   logic [7:0] cfgAddr;
   logic respOvf;

   int testCount = 0;
   int failCount = 0;
   int cycleCount = 0;
   logic [7:0] respQ [$];
   logic [7:0] expRegs [NREGS];

   mcu_cmd_decoder #(
      .NUM_REGS(NREGS),
      .ID_BYTE(8'h56),
      .TIMEOUT(TOUT),
      .TX_PULSE(TXP),
      .TX_GAP(TXG)
   ) dut (
      .clk_dot4x_i(clk),
      .rst_i(rst),
      .rx_data_4x_i(rxData),
      .rx_new_data_4x_i(rxNew),
      .tx_data_4x_o(txData),
      .tx_new_data_4x_o(txNew),
      .cfg_regs_o(cfgRegs),
      .cfg_wr_o(cfgWr),
      .cfg_addr_o(cfgAddr),
      .resp_ovf_o(respOvf)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to measure response spacing
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Compare one observed value against its expected value and log mismatches
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Flatten the reference register image
   function automatic logic [127:0] packRegs();
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < NREGS; k++) r[8*k +: 8] = expRegs[k];
      return r;
   endfunction

   // Return the reference register image to its reset contents
   task automatic resetModel();
      for (int k = 0; k < NREGS; k++) expRegs[k] = (k == 0) ? 8'h56 : 8'h00;
   endtask

   // Drive one byte strobe for one cycle; called on a falling edge
   task automatic applyStimulus(input logic [7:0] b);
      rxData = b;
      rxNew  = 1'b1;
      @(negedge clk);
      rxNew  = 1'b0;
   endtask

   // Drive a complete frame, appending the checksum byte when that build is used
   task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data);
      applyStimulus(cmd);
      applyStimulus(addr);
      applyStimulus(data);
`ifdef CMD_CHECKSUM_EN
      applyStimulus(cmd ^ addr ^ data);
`endif
   endtask

   // Wait for all queued responses to appear, then let the transmitter go idle
   task automatic drainResponses();
      int waited = 0;
      while (respQ.size() != 0 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("drainQueue", 128'(respQ.size()), 128'd0);
      repeat (TXP + TXG + 4) @(negedge clk);
   endtask

   // Response monitor: pop expectations on each new pulse and check pulse shape
   logic prevNew = 1'b0;
   int pulseLen = 0;
   int lastRise = -1;
   logic [7:0] expByte;
   always @(negedge clk) begin
      if (rst) begin
         prevNew  = 1'b0;
         pulseLen = 0;
         lastRise = -1;
      end else begin
         if (txNew) begin
            if (!prevNew) begin
               if (respQ.size() == 0) begin
                  checkOutput("respQueueDepth", 128'(respQ.size()), 128'd1);
               end else begin
                  expByte = respQ.pop_front();
                  checkOutput("respByte", 128'(txData), 128'(expByte));
               end
               if (lastRise >= 0)
                  checkOutput("respSpacing", 128'((cycleCount - lastRise) >= (TXP + TXG)), 128'd1);
               lastRise = cycleCount;
               pulseLen = 0;
            end
            pulseLen++;
         end else if (prevNew) begin
            checkOutput("pulseLen", 128'(pulseLen), 128'(TXP));
         end
         prevNew = txNew;
      end
   end

   // Safety net so the run always ends
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      resetModel();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      checkOutput("rstTxNew", 128'(txNew), 128'd0);
      checkOutput("rstTxData", 128'(txData), 128'd0);
      checkOutput("rstCfgWr", 128'(cfgWr), 128'd0);
      checkOutput("rstCfgAddr", 128'(cfgAddr), 128'd0);
      checkOutput("rstOvf", 128'(respOvf), 128'd0);
      checkOutput("rstRegs", cfgRegs, packRegs());

      // Write then read back, with exact write/response latency
      respQ.push_back(8'hA5);
      sendFrame(8'h01, 8'h05, 8'h3C);
      expRegs[5] = 8'h3C;
      checkOutput("wrEarly", 128'(cfgWr), 128'd0);
      @(negedge clk);
      checkOutput("wrPulse", 128'(cfgWr), 128'd1);
      checkOutput("wrAddr", 128'(cfgAddr), 128'd5);
      checkOutput("wrReg5", 128'(cfgRegs[47:40]), 128'h3C);
      checkOutput("txStart", 128'(txNew), 128'd1);
      @(negedge clk);
      checkOutput("wrPulseEnd", 128'(cfgWr), 128'd0);
      respQ.push_back(8'h3C);
      sendFrame(8'h02, 8'h05, 8'h00);
      drainResponses();
      checkOutput("regsAfterWrite", cfgRegs, packRegs());

      // Read-only register and out-of-range accesses
      respQ.push_back(8'hEE);
      sendFrame(8'h01, 8'h00, 8'h77);
      drainResponses();
      checkOutput("regsReadOnly", cfgRegs, packRegs());
      respQ.push_back(8'hEE);
      sendFrame(8'h02, 8'h10, 8'h00);
      drainResponses();
      respQ.push_back(8'h56);
      sendFrame(8'h02, 8'h00, 8'h00);
      drainResponses();

      // Invalid command consumes a full frame; the next frame parses normally
      respQ.push_back(8'hEE);
      respQ.push_back(8'h00);
      sendFrame(8'h09, 8'h02, 8'h55);
      sendFrame(8'h02, 8'h02, 8'h00);
      drainResponses();
      checkOutput("regsInvalid", cfgRegs, packRegs());

      // Inter-byte timeout discards the partial write
      respQ.push_back(8'h00);
      applyStimulus(8'h01);
      applyStimulus(8'h03);
      repeat (TOUT + 2) @(negedge clk);
      sendFrame(8'h02, 8'h03, 8'h00);
      drainResponses();
      checkOutput("regsTimeout", cfgRegs, packRegs());
      checkOutput("ovfBeforeBurst", 128'(respOvf), 128'd0);

      // Three back-to-back writes: third response dropped, all writes land
      respQ.push_back(8'hA5);
      respQ.push_back(8'hA5);
      sendFrame(8'h01, 8'h07, 8'h11);
      sendFrame(8'h01, 8'h08, 8'h22);
      sendFrame(8'h01, 8'h09, 8'h33);
      expRegs[7] = 8'h11;
      expRegs[8] = 8'h22;
      expRegs[9] = 8'h33;
      repeat (2) @(negedge clk);
      checkOutput("ovfSet", 128'(respOvf), 128'd1);
      checkOutput("regsBurst", cfgRegs, packRegs());
      drainResponses();
      checkOutput("ovfSticky", 128'(respOvf), 128'd1);

`ifdef CMD_CHECKSUM_EN
      // Good checksum writes, bad checksum is rejected without side effect
      respQ.push_back(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h04);
      applyStimulus(8'hAA);
      applyStimulus(8'hAF);
      expRegs[4] = 8'hAA;
      drainResponses();
      respQ.push_back(8'hEE);
      applyStimulus(8'h01);
      applyStimulus(8'h04);
      applyStimulus(8'hBB);
      applyStimulus(8'h00);
      drainResponses();
      checkOutput("regsChecksum", cfgRegs, packRegs());
`endif

      // Reset in the middle of a frame clears everything and resynchronises
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      checkOutput("midRstOvf", 128'(respOvf), 128'd0);
      checkOutput("midRstRegs", cfgRegs, packRegs());
      checkOutput("midRstTxData", 128'(txData), 128'd0);
      respQ.push_back(8'hEE);
      sendFrame(8'h09, 8'h02, 8'h55);
      drainResponses();
      checkOutput("regsAfterReset", cfgRegs, packRegs());

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
